// File: rtl/addsub_byte_serial.sv
// Byte-serial W-bit add/subtract engine: one 8-bit adder is reused NBYTES times,
// LSB first, with the carry chained across cycles. Valid/ready on both sides.
module addsub_byte_serial #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   s,
    output logic                  co,
    output logic                  ofl,
    output logic                  z
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_q, b_q;
    logic            sub_q;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic            accept;
    logic            last;
    logic [7:0]      a_byte, bx_byte;
    logic [8:0]      sum;
    logic [W-1:0]    s_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and handshake outputs; both outputs depend only on state (and rst_n)
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    // Byte-wide datapath: {c, r} = a[i] + (b[i] ^ {8{sub}}) + carry
    always_comb begin
        a_byte  = a_q[8*idx +: 8];
        bx_byte = b_q[8*idx +: 8] ^ {8{sub_q}};
        sum     = {1'b0, a_byte} + {1'b0, bx_byte} + {8'd0, carry};
        s_next  = s;
        s_next[8*idx +: 8] = sum[7:0];
    end

    // NOTE: operand holding registers carry no reset; they are only read after an acceptance loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ofl   <= 1'b0;
            z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= sub;
                        idx   <= '0;
                        s     <= '0;
                    end
                end
                RUN: begin
                    s     <= s_next;
                    carry <= sum[8];
                    if (last) begin
                        co  <= sum[8];
                        ofl <= (a_byte[7] & bx_byte[7] & ~sum[7]) |
                               (~a_byte[7] & ~bx_byte[7] & sum[7]);
                        z   <= (s_next == '0);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_byte_serial.sv
// Self-checking bench for addsub_byte_serial: directed corner cases plus random
// operations compared against a whole-word arithmetic reference model.
module tb_addsub_byte_serial;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co, ofl, z;

    int n_cmp = 0;
    int n_err = 0;

    addsub_byte_serial #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ofl       (ofl),
        .z         (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic with signed-overflow from operand/result signs
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] es, output logic eco, output logic eofl,
                         output logic ez);
        logic [W:0] full;
        if (msub) full = {1'b0, ma} - {1'b0, mb} + (1 << W);
        else      full = {1'b0, ma} + {1'b0, mb};
        es  = full[W-1:0];
        eco = full[W];
        if (msub) eofl = (ma[W-1] != mb[W-1]) && (es[W-1] != ma[W-1]);
        else      eofl = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
        ez  = (es == '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; 'hold' cycles of backpressure in DONE with new operands offered
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                         input int hold);
        logic [W-1:0] es;
        logic eco, eofl, ez;
        int cyc;
        model(oa, ob, osub, es, eco, eofl, ez);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("in_ready_before_op", in_ready, 1);
        a = oa; b = ob; sub = osub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = ~osub;
        check("in_ready_after_accept", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", cyc, NBYTES);
        check("s", s, es);
        check("co", co, eco);
        check("ofl", ofl, eofl);
        check("z", z, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_s", s, es);
            check("bp_flags", {co, ofl, z}, {eco, eofl, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_idle", in_ready, 1);
        check("s_kept", s, es);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_flags", {co, ofl, z}, 3'b000);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        do_op(32'h0000FFFF, 32'h00000001, 1'b0, 0);
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        do_op(32'h80000000, 32'h00000001, 1'b1, 0);
        do_op(32'h00000005, 32'h00000005, 1'b1, 0);
        do_op(32'h00000003, 32'h00000005, 1'b1, 5);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0);

        // Abort during byte 2: acceptance, then two RUN edges, then reset
        a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready_low", in_ready, 0);
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_s", s, 0);
        check("mid_rst_flags", {co, ofl, z}, 3'b000);
        check("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_idle", in_ready, 1);
        do_op(32'h12345678, 32'h11111111, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
